// File: rtl/touch_key_decode_if.sv
// rtl/touch_key_decode_if.sv - touch-controller inputs and soft-key event outputs
interface touch_key_decode_if;
  logic        touch_valid;
  logic [2:0]  tp_num;
  logic [31:0] tp1_xy;
  logic        key_press;
  logic        key_long;
  logic        key_rpt;
  logic        key_release;
  logic [2:0]  key_code;
  logic        key_hold;

  modport master (
    output touch_valid, tp_num, tp1_xy,
    input  key_press, key_long, key_rpt, key_release, key_code, key_hold
  );

  modport slave (
    input  touch_valid, tp_num, tp1_xy,
    output key_press, key_long, key_rpt, key_release, key_code, key_hold
  );
endinterface

// File: rtl/touch_key_decode.sv
// rtl/touch_key_decode.sv - debounced soft-key events for an 8-button vertical column
module touch_key_decode #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000,
  parameter int BTN_X0       = 720,
  parameter int BTN_W        = 80,
  parameter int BTN_Y0       = 0,
  parameter int BTN_PITCH    = 60,
  parameter int BTN_H        = 56
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  touch_key_decode_if.slave  bus
);

  localparam logic [23:0] DEB_THR  = 24'(DEBOUNCE_CYC);
  localparam logic [23:0] LONG_THR = 24'(LONG_CYC);
  localparam logic [23:0] RPT_THR  = 24'(REPEAT_CYC);
  localparam logic [15:0] X_LO     = 16'(BTN_X0);
  localparam logic [15:0] X_SPAN   = 16'(BTN_W);
  localparam logic [15:0] Y_SPAN   = 16'(BTN_H);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  logic [15:0] pos_x;
  logic [15:0] pos_y;
  logic [7:0]  btn_hit;
  logic        hit;
  logic [2:0]  hit_idx;
  logic        qual;

  state_t      state;
  logic [2:0]  cand;
  logic [23:0] cnt;
  logic [23:0] hcnt;
  logic [23:0] rcnt;
  logic        key_press_q;
  logic        key_long_q;
  logic        key_rpt_q;
  logic        key_release_q;
  logic [2:0]  key_code_q;
  logic        key_hold_q;

  assign pos_x = bus.tp1_xy[31:16];
  assign pos_y = bus.tp1_xy[15:0];

  // Range check as (v - lo) < span: a coordinate below lo wraps to a large
  // value, so one unsigned compare covers both edges of each axis.
  for (genvar gi = 0; gi < 8; gi++) begin : g_btn
    localparam logic [15:0] Y_LO = 16'(BTN_Y0 + gi * BTN_PITCH);
    assign btn_hit[gi] = (16'(pos_x - X_LO) < X_SPAN) &&
                         (16'(pos_y - Y_LO) < Y_SPAN);
  end

  assign hit = |btn_hit;

  // Buttons never overlap, so at most one bit is set; encode it to an index.
  always_comb begin
    hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (btn_hit[i]) hit_idx = 3'(i);
    end
  end

  // Outside IDLE the touch only counts if it stays on the latched button.
  assign qual = bus.touch_valid && (bus.tp_num != 3'd0) && hit &&
                ((state == ST_IDLE) || (hit_idx == cand));

  // Key FSM: debounce, hold timing, auto-repeat and release, all outputs registered.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      cand          <= 3'd0;
      cnt           <= 24'd0;
      hcnt          <= 24'd0;
      rcnt          <= 24'd0;
      key_press_q   <= 1'b0;
      key_long_q    <= 1'b0;
      key_rpt_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_code_q    <= 3'd0;
      key_hold_q    <= 1'b0;
    end else begin
      key_press_q   <= 1'b0;
      key_long_q    <= 1'b0;
      key_rpt_q     <= 1'b0;
      key_release_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          key_hold_q <= 1'b0;
          cnt        <= 24'd0;
          hcnt       <= 24'd0;
          rcnt       <= 24'd0;
          if (qual) begin
            cand <= hit_idx;
            if (DEB_THR == 24'd1) begin
              key_press_q <= 1'b1;
              key_code_q  <= hit_idx;
              key_hold_q  <= 1'b1;
              state       <= ST_HOLD;
            end else begin
              cnt   <= 24'd1;
              state <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!qual) begin
            cnt   <= 24'd0;
            state <= ST_IDLE;
          end else if (cnt + 24'd1 == DEB_THR) begin
            key_press_q <= 1'b1;
            key_code_q  <= cand;
            key_hold_q  <= 1'b1;
            cnt         <= 24'd0;
            hcnt        <= 24'd0;
            rcnt        <= 24'd0;
            state       <= ST_HOLD;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (!qual) begin
            // Absence is checked first, so release wins over long/repeat.
            if (rcnt + 24'd1 == DEB_THR) begin
              key_release_q <= 1'b1;
              rcnt          <= 24'd0;
              hcnt          <= 24'd0;
              state         <= ST_IDLE;
            end else begin
              rcnt <= rcnt + 24'd1;
            end
          end else begin
            rcnt <= 24'd0;
            if (state == ST_HOLD) begin
              if (hcnt + 24'd1 == LONG_THR) begin
                key_long_q <= 1'b1;
                hcnt       <= 24'd0;
                state      <= ST_REPEAT;
              end else begin
                hcnt <= hcnt + 24'd1;
              end
            end else begin
              if (hcnt + 24'd1 == RPT_THR) begin
                key_rpt_q <= 1'b1;
                hcnt      <= 24'd0;
              end else begin
                hcnt <= hcnt + 24'd1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.key_press   = key_press_q;
  assign bus.key_long    = key_long_q;
  assign bus.key_rpt     = key_rpt_q;
  assign bus.key_release = key_release_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_hold    = key_hold_q;

endmodule
